h_data_memory: RTL and testbench

- Hack data-memory subsystem, directly downstream of the CPU. Consumes addressM/outM/writeM and returns inM in the same cycle.
- Contains 16K-word general RAM, an 8K-word screen buffer with an independent registered display read port, and a memory-mapped keyboard register backed by a small handshake FIFO.
- Single clock domain, shared with the CPU and PC.

---
 rtl/h_data_memory_pkg.sv | 25 ++
 rtl/h_data_memory_kbd_fifo.sv | 65 ++++++
 rtl/h_data_memory.sv | 100 ++++++++++
 tb/tb_h_data_memory.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/h_data_memory_pkg.sv
// h_data_memory_pkg
//   Shared definitions for the Hack data-memory subsystem: the address-map
//   constants and the region type produced by the CPU address decoder.
package h_data_memory_pkg;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_SCREEN   = 2'd1,
    REG_KBD      = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  // Bit 15 set always lands above KBD_ADDR, so it falls into UNMAPPED.
  function automatic region_e decode_region(input logic [15:0] addr);
    if (addr < SCREEN_BASE)    return REG_RAM;
    else if (addr < KBD_ADDR)  return REG_SCREEN;
    else if (addr == KBD_ADDR) return REG_KBD;
    else                       return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/h_data_memory_kbd_fifo.sv
// h_kbd_fifo
//   Keyboard handshake FIFO: circular buffer with read/write pointers and an
//   occupancy counter.
// Ports:
//   clock, reset       - clock, asynchronous active-low reset
//   push_data/valid    - keycode offered by the keyboard source
//   push_ready         - FIFO can accept (not full)
//   pop                - drop the head entry (ignored when empty)
//   head               - current head entry (undefined when empty)
//   count              - occupancy, 0..DEPTH
//   empty              - occupancy is zero
module h_kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   push_data,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic          pop,
  output logic [15:0]   head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  assign push_ready = (count != FULL_CNT);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];

  // An empty FIFO ignores the pop even if a push lands on the same edge.
  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop && !empty;

  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/h_data_memory.sv
// h_data_memory
//   Hack data memory: 16K-word RAM, 8K-word screen buffer with a registered
//   display read port, and a memory-mapped keyboard register fed by a FIFO.
//   CPU reads are combinational; CPU writes happen on the rising clock edge.
// Ports:
//   clock, reset        - system clock, asynchronous active-low reset
//   address, in, load   - CPU addressM / outM / writeM
//   out                 - CPU inM (combinational)
//   scr_addr, scr_data  - display read port, 1-cycle latency
//   key_data, key_valid, key_ready - keyboard source handshake
//   kbd_count           - keyboard FIFO occupancy
//   bus_err             - sticky unmapped-write flag (only with HMEM_BUS_ERR_EN)
// Optional feature macro: HMEM_BUS_ERR_EN
module h_data_memory
  import h_data_memory_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic [15:0] key_data,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [2:0]  kbd_count
`ifdef HMEM_BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int SAW = $clog2(SCREEN_WORDS);
  localparam int CW  = $clog2(KBD_DEPTH + 1);

  logic [15:0]   ram    [RAM_WORDS];
  logic [15:0]   screen [SCREEN_WORDS];
  region_e       region;
  logic [15:0]   kbd_head;
  logic          kbd_empty;
  logic [CW-1:0] kbd_cnt;
  logic          kbd_pop;

  assign region  = decode_region(address);
  assign kbd_pop = load && (region == REG_KBD);

  h_kbd_fifo #(
    .DEPTH (KBD_DEPTH),
    .CW    (CW)
  ) u_kbd_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_data  (key_data),
    .push_valid (key_valid),
    .push_ready (key_ready),
    .pop        (kbd_pop),
    .head       (kbd_head),
    .count      (kbd_cnt),
    .empty      (kbd_empty)
  );

  assign kbd_count = 3'(kbd_cnt);

  // Reads see only stored state, so a same-edge write never leaks into out.
  always_comb begin
    out = 16'h0000;
    case (region)
      REG_RAM:    out = ram[address[RAW-1:0]];
      REG_SCREEN: out = screen[address[SAW-1:0]];
      REG_KBD:    out = kbd_empty ? 16'h0000 : kbd_head;
      default:    out = 16'h0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (load && (region == REG_RAM))    ram[address[RAW-1:0]]    <= in;
    if (load && (region == REG_SCREEN)) screen[address[SAW-1:0]] <= in;
  end

  // Nonblocking read of the array gives read-before-write on a shared word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) scr_data <= 16'h0000;
    else        scr_data <= screen[scr_addr[SAW-1:0]];
  end

`ifdef HMEM_BUS_ERR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               bus_err <= 1'b0;
    else if (load && (region == REG_UNMAPPED)) bus_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_h_data_memory.sv
module tb_h_data_memory;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [15:0] key_data;
  logic        key_valid;
  logic        key_ready;
  logic [2:0]  kbd_count;
`ifdef HMEM_BUS_ERR_EN
  logic        bus_err;
`endif

  int errors = 0;
  int checks = 0;

  h_data_memory dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .in        (in),
    .load      (load),
    .out       (out),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .kbd_count (kbd_count)
`ifdef HMEM_BUS_ERR_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a; in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic push_key(input logic [15:0] k);
    key_data = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pop_key();
    address = 16'h6000; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; address = 16'h6000; in = 16'h0; load = 1'b0;
    scr_addr = 13'd5; key_data = 16'h0; key_valid = 1'b0;
    tick(); tick();
    checks++; if (kbd_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", kbd_count); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", key_ready); end
    checks++; if (scr_data !== 16'h0000) begin errors++; $display("FAIL reset_scr got=%h exp=0000", scr_data); end
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_kbd_read got=%h exp=0000", out); end
`ifdef HMEM_BUS_ERR_EN
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
`endif
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_ram();
    wr(16'h0010, 16'h1234);
    address = 16'h0010; #1;
    checks++; if (out !== 16'h1234) begin errors++; $display("FAIL ram_rt1 got=%h exp=1234", out); end
    wr(16'h3FFF, 16'hBEEF);
    address = 16'h3FFF; #1;
    checks++; if (out !== 16'hBEEF) begin errors++; $display("FAIL ram_top got=%h exp=beef", out); end
    address = 16'h0010; #1;
    checks++; if (out !== 16'h1234) begin errors++; $display("FAIL ram_keep got=%h exp=1234", out); end
    wr(16'h0000, 16'h0F0F);
    wr(16'h2001, 16'h0101);
  endtask

  task automatic test_screen();
    scr_addr = 13'd5;
    wr(16'h4005, 16'h5555);
    wr(16'h4005, 16'hAAAA);
    checks++; if (scr_data !== 16'h5555) begin errors++; $display("FAIL scr_rbw got=%h exp=5555", scr_data); end
    tick();
    checks++; if (scr_data !== 16'hAAAA) begin errors++; $display("FAIL scr_new got=%h exp=aaaa", scr_data); end
    address = 16'h4005; #1;
    checks++; if (out !== 16'hAAAA) begin errors++; $display("FAIL scr_cpu_read got=%h exp=aaaa", out); end
  endtask

  task automatic test_kbd_fill();
    logic [15:0] exp_heads [4];
    exp_heads[0] = 16'h0042; exp_heads[1] = 16'h0043;
    exp_heads[2] = 16'h0044; exp_heads[3] = 16'h0000;
    for (int i = 0; i < 4; i++) push_key(16'h0041 + 16'(i));
    checks++; if (kbd_count !== 3'd4) begin errors++; $display("FAIL kbd_full_count got=%0d exp=4", kbd_count); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL kbd_full_ready got=%b exp=0", key_ready); end
    address = 16'h6000; #1;
    checks++; if (out !== 16'h0041) begin errors++; $display("FAIL kbd_head0 got=%h exp=0041", out); end
    for (int i = 0; i < 4; i++) begin
      pop_key(); #1;
      checks++; if (out !== exp_heads[i]) begin errors++; $display("FAIL kbd_drain%0d got=%h exp=%h", i, out, exp_heads[i]); end
      checks++; if (kbd_count !== 3'(3 - i)) begin errors++; $display("FAIL kbd_drain_count%0d got=%0d exp=%0d", i, kbd_count, 3 - i); end
      if (i == 0) begin
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_after_pop got=%b exp=1", key_ready); end
      end
    end
  endtask

  task automatic test_back_to_back();
    push_key(16'h0061);
    push_key(16'h0062);
    key_data = 16'h0051; key_valid = 1'b1; address = 16'h6000; load = 1'b1;
    tick();
    key_valid = 1'b0; load = 1'b0; #1;
    checks++; if (kbd_count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d exp=2", kbd_count); end
    checks++; if (out !== 16'h0062) begin errors++; $display("FAIL simul_head got=%h exp=0062", out); end
    pop_key();
    pop_key();
    checks++; if (kbd_count !== 3'd0) begin errors++; $display("FAIL simul_drained got=%0d exp=0", kbd_count); end
    key_data = 16'h0051; key_valid = 1'b1; address = 16'h6000; load = 1'b1; #1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL empty_simul_read got=%h exp=0000", out); end
    tick();
    key_valid = 1'b0; load = 1'b0; #1;
    checks++; if (kbd_count !== 3'd1) begin errors++; $display("FAIL empty_simul_count got=%0d exp=1", kbd_count); end
    checks++; if (out !== 16'h0051) begin errors++; $display("FAIL empty_simul_head got=%h exp=0051", out); end
    push_key(16'h0071);
    push_key(16'h0072);
    push_key(16'h0073);
    key_data = 16'h0074; key_valid = 1'b1; address = 16'h6000; load = 1'b1;
    tick();
    key_valid = 1'b0; load = 1'b0; #1;
    checks++; if (kbd_count !== 3'd3) begin errors++; $display("FAIL full_simul_count got=%0d exp=3", kbd_count); end
    checks++; if (out !== 16'h0071) begin errors++; $display("FAIL full_simul_head got=%h exp=0071", out); end
  endtask

  task automatic test_unmapped();
    wr(16'h6001, 16'h7777);
    address = 16'h6001; #1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL unmap_6001 got=%h exp=0000", out); end
`ifdef HMEM_BUS_ERR_EN
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_set got=%b exp=1", bus_err); end
`endif
    wr(16'h8000, 16'h7777);
    address = 16'h8000; #1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL unmap_8000 got=%h exp=0000", out); end
    address = 16'h0000; #1;
    checks++; if (out !== 16'h0F0F) begin errors++; $display("FAIL unmap_ram0 got=%h exp=0f0f", out); end
    address = 16'h2001; #1;
    checks++; if (out !== 16'h0101) begin errors++; $display("FAIL unmap_ram2001 got=%h exp=0101", out); end
    address = 16'h5FFF; #1;
    tick(); tick();
`ifdef HMEM_BUS_ERR_EN
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got=%b exp=1", bus_err); end
`endif
  endtask

  task automatic test_reset_mid();
    scr_addr = 13'd5; tick();
    checks++; if (kbd_count !== 3'd3) begin errors++; $display("FAIL pre_reset_count got=%0d exp=3", kbd_count); end
    checks++; if (scr_data !== 16'hAAAA) begin errors++; $display("FAIL pre_reset_scr got=%h exp=aaaa", scr_data); end
    #2 reset = 1'b0; #1;
    checks++; if (kbd_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", kbd_count); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", key_ready); end
    checks++; if (scr_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_scr got=%h exp=0000", scr_data); end
    address = 16'h6000; #1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL mid_reset_kbd got=%h exp=0000", out); end
    address = 16'h0010; #1;
    checks++; if (out !== 16'h1234) begin errors++; $display("FAIL mid_reset_ram got=%h exp=1234", out); end
`ifdef HMEM_BUS_ERR_EN
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_reset_bus_err got=%b exp=0", bus_err); end
`endif
    tick();
    #2 reset = 1'b1;
    tick();
    push_key(16'h0099);
    address = 16'h6000; #1;
    checks++; if (out !== 16'h0099) begin errors++; $display("FAIL post_reset_push got=%h exp=0099", out); end
    checks++; if (kbd_count !== 3'd1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", kbd_count); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen();
    test_kbd_fill();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
